// File: rtl/hdlc_rx_protocol_checker_if.sv
// Rx status nets observed by the HDLC receive protocol checker, plus its error-reporting outputs.
// The master side is whatever owns the Rx channels; the checker attaches through the slave modport.
interface hdlc_rx_protocol_checker_if #(
  parameter int NUM_CH = 1,
  parameter int CNT_W  = 16
);
  logic                  Enable;
  logic                  ClrErr;
  logic [NUM_CH-1:0]     Rx;
  logic [NUM_CH-1:0]     Rx_FlagDetect;
  logic [NUM_CH-1:0]     Rx_ValidFrame;
  logic [NUM_CH-1:0]     Rx_AbortDetect;
  logic [NUM_CH-1:0]     Rx_AbortSignal;
  logic [NUM_CH-1:0]     Rx_EoF;
  logic [NUM_CH-1:0]     Rx_Overflow;
  logic [NUM_CH-1:0]     Rx_FrameError;
  logic [NUM_CH-1:0]     Rx_Ready;
  logic [3*NUM_CH-1:0]   ErrFlag;
  logic [CNT_W-1:0]      ErrCnt;
  logic                  FirstErrValid;
  logic [3:0]            FirstErrCh;
  logic [1:0]            FirstErrType;

  modport master (
    output Enable, ClrErr, Rx, Rx_FlagDetect, Rx_ValidFrame, Rx_AbortDetect, Rx_AbortSignal,
           Rx_EoF, Rx_Overflow, Rx_FrameError, Rx_Ready,
    input  ErrFlag, ErrCnt, FirstErrValid, FirstErrCh, FirstErrType
  );

  modport slave (
    input  Enable, ClrErr, Rx, Rx_FlagDetect, Rx_ValidFrame, Rx_AbortDetect, Rx_AbortSignal,
           Rx_EoF, Rx_Overflow, Rx_FrameError, Rx_Ready,
    output ErrFlag, ErrCnt, FirstErrValid, FirstErrCh, FirstErrType
  );
endinterface

// File: rtl/hdlc_rx_protocol_checker.sv
// Run-time checker for HDLC Rx channels: flag-detect latency, abort signalling and end-of-frame
// status consistency, with sticky per-channel flags, a saturating error count and first-error capture.
module hdlc_rx_protocol_checker #(
  parameter int NUM_CH    = 1,
  parameter int FLAG_LAT  = 2,
  parameter int ABORT_LAT = 1,
  parameter int CNT_W     = 16
) (
  input  logic                    Clk,
  input  logic                    Rst,
  hdlc_rx_protocol_checker_if.slave bus
);

  typedef enum logic {IDLE, CHK_RDY} state_t;

  localparam int SUM_W = CNT_W + 7;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

  logic [3*NUM_CH-1:0] err;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [6:0]           sr_reg;
    logic [2:0]           fill_reg;
    logic [FLAG_LAT-1:0]  flag_pipe_reg, flag_pipe_next;
    logic [ABORT_LAT-1:0] abort_pipe_reg, abort_pipe_next;
    logic                 eof_prev_reg;
    state_t               state_reg, state_next;
    logic                 match, abort_req, status_err;

    // sr_reg[6] is the oldest bit; the current Rx completes the 8-bit window.
    assign match     = ({sr_reg, bus.Rx[gi]} == 8'b0111_1110) && (fill_reg == 3'd7) && bus.Enable;
    assign abort_req = bus.Rx_AbortDetect[gi] && bus.Rx_ValidFrame[gi] && bus.Enable;

    if (FLAG_LAT == 1) begin : g_flag1
      assign flag_pipe_next = match;
    end else begin : g_flagn
      assign flag_pipe_next = {flag_pipe_reg[FLAG_LAT-2:0], match};
    end

    if (ABORT_LAT == 1) begin : g_abort1
      assign abort_pipe_next = abort_req;
    end else begin : g_abortn
      assign abort_pipe_next = {abort_pipe_reg[ABORT_LAT-2:0], abort_req};
    end

    always_ff @(posedge Clk) begin
      if (Rst) begin
        sr_reg         <= '0;
        fill_reg       <= '0;
        flag_pipe_reg  <= '0;
        abort_pipe_reg <= '0;
        eof_prev_reg   <= 1'b0;
        state_reg      <= IDLE;
      end else begin
        sr_reg       <= {sr_reg[5:0], bus.Rx[gi]};
        eof_prev_reg <= bus.Rx_EoF[gi];
        state_reg    <= state_next;
        if (fill_reg != 3'd7) fill_reg <= fill_reg + 3'd1;
        // Pending expectations are dropped while disabled; the bit window keeps filling.
        if (bus.Enable) begin
          flag_pipe_reg  <= flag_pipe_next;
          abort_pipe_reg <= abort_pipe_next;
        end else begin
          flag_pipe_reg  <= '0;
          abort_pipe_reg <= '0;
        end
      end
    end

    always_comb begin
      state_next = IDLE;
      status_err = 1'b0;
      if (bus.Enable) begin
        case (state_reg)
          IDLE: begin
            if (bus.Rx_EoF[gi] && !eof_prev_reg) begin
              if (bus.Rx_AbortSignal[gi]) begin
                status_err = bus.Rx_Overflow[gi] || bus.Rx_FrameError[gi];
                state_next = CHK_RDY;
              end else if (bus.Rx_Overflow[gi]) begin
                status_err = bus.Rx_FrameError[gi] || !bus.Rx_Ready[gi];
              end else if (bus.Rx_FrameError[gi]) begin
                status_err = bus.Rx_Ready[gi];
              end else begin
                status_err = !bus.Rx_Ready[gi] || bus.Rx_Overflow[gi];
              end
            end
          end
          CHK_RDY: status_err = bus.Rx_Ready[gi];
          default: status_err = 1'b0;
        endcase
      end
    end

    assign err[3*gi]   = bus.Enable && flag_pipe_reg[FLAG_LAT-1] && !bus.Rx_FlagDetect[gi];
    assign err[3*gi+1] = bus.Enable && abort_pipe_reg[ABORT_LAT-1] && !bus.Rx_AbortSignal[gi];
    assign err[3*gi+2] = status_err;
  end

  logic [SUM_W-1:0] err_pop, cnt_sum;
  logic [3:0]       first_ch;
  logic [1:0]       first_type;

  // Scanning downward leaves the lowest set index: lowest channel first, then lowest type.
  always_comb begin
    err_pop    = '0;
    first_ch   = '0;
    first_type = '0;
    for (int i = 3*NUM_CH-1; i >= 0; i--) begin
      err_pop = err_pop + SUM_W'(err[i]);
      if (err[i]) begin
        first_ch   = 4'(i / 3);
        first_type = 2'(i % 3);
      end
    end
  end

  assign cnt_sum = (bus.ClrErr ? '0 : SUM_W'(bus.ErrCnt)) + err_pop;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      bus.ErrFlag       <= '0;
      bus.ErrCnt        <= '0;
      bus.FirstErrValid <= 1'b0;
      bus.FirstErrCh    <= '0;
      bus.FirstErrType  <= '0;
    end else begin
      bus.ErrFlag <= (bus.ClrErr ? '0 : bus.ErrFlag) | err;
      bus.ErrCnt  <= (cnt_sum > CNT_MAX) ? '1 : cnt_sum[CNT_W-1:0];
      if (bus.ClrErr || !bus.FirstErrValid) begin
        bus.FirstErrValid <= |err;
        bus.FirstErrCh    <= first_ch;
        bus.FirstErrType  <= first_type;
      end
    end
  end

endmodule

// File: tb/tb_hdlc_rx_protocol_checker.sv
// Randomized scoreboard bench for hdlc_rx_protocol_checker with a cycle-indexed reference model
// and a handful of directed scenarios anchored to hand-computed outputs.
module tb_hdlc_rx_protocol_checker;
  localparam int NUM_CH    = 4;
  localparam int FLAG_LAT  = 2;
  localparam int ABORT_LAT = 1;
  localparam int CNT_W     = 5;
  localparam int NB        = 3*NUM_CH;
  localparam int MAXC      = 8192;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  hdlc_rx_protocol_checker_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

  hdlc_rx_protocol_checker #(
    .NUM_CH(NUM_CH), .FLAG_LAT(FLAG_LAT), .ABORT_LAT(ABORT_LAT), .CNT_W(CNT_W)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .bus(bus)
  );

  typedef struct {
    logic [NB-1:0] flag;
    int            cnt;
    bit            fv;
    int            fch;
    int            ftype;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Stimulus for the next cycle
  bit                t_rst, t_en, t_clr;
  logic [NUM_CH-1:0] t_rx, t_fd, t_vf, t_ad, t_as, t_eof, t_ovf, t_fe, t_rdy;

  // Reference model state: full bit history since reset, and expectations indexed by absolute cycle
  int            cyc = 0;
  int            nbits   [NUM_CH];
  bit            hist    [NUM_CH][MAXC];
  bit            flag_due[NUM_CH][MAXC+16];
  bit            abrt_due[NUM_CH][MAXC+16];
  int            chk_due [NUM_CH];
  bit            eof_prev[NUM_CH];
  logic [NB-1:0] m_flag;
  int            m_cnt, m_fch, m_ftype;
  bit            m_fv;

  // Random source state
  logic [7:0] chunk_word[NUM_CH];
  int         chunk_len [NUM_CH];
  int         dis_left = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drop_future(int c);
    for (int d = 0; d <= 8; d++) begin
      flag_due[c][cyc+d] = 1'b0;
      abrt_due[c][cyc+d] = 1'b0;
    end
    chk_due[c] = -1;
  endtask

  task automatic model_step();
    logic [NB-1:0] err;
    logic [7:0]    pat;
    bit            m;
    int            idx;
    exp_t          e;
    err = '0;
    pat = 8'h7E;
    if (t_rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        nbits[c] = 0;
        eof_prev[c] = 1'b0;
        drop_future(c);
      end
      m_flag = '0; m_cnt = 0; m_fv = 1'b0; m_fch = 0; m_ftype = 0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        hist[c][nbits[c]] = t_rx[c];
        nbits[c]++;
        m = 1'b0;
        if (t_en && nbits[c] >= 8) begin
          m = 1'b1;
          for (int k = 0; k < 8; k++)
            if (hist[c][nbits[c]-8+k] != pat[7-k]) m = 1'b0;
        end
        if (!t_en) begin
          drop_future(c);
        end else begin
          if (flag_due[c][cyc] && !t_fd[c]) err[3*c] = 1'b1;
          if (abrt_due[c][cyc] && !t_as[c]) err[3*c+1] = 1'b1;
          if (m) flag_due[c][cyc+FLAG_LAT] = 1'b1;
          if (t_ad[c] && t_vf[c]) abrt_due[c][cyc+ABORT_LAT] = 1'b1;
          if (chk_due[c] == cyc) begin
            if (t_rdy[c]) err[3*c+2] = 1'b1;
            chk_due[c] = -1;
          end else if (t_eof[c] && !eof_prev[c]) begin
            if (t_as[c]) begin
              if (t_ovf[c] || t_fe[c]) err[3*c+2] = 1'b1;
              chk_due[c] = cyc + 1;
            end else if (t_ovf[c]) begin
              if (t_fe[c] || !t_rdy[c]) err[3*c+2] = 1'b1;
            end else if (t_fe[c]) begin
              if (t_rdy[c]) err[3*c+2] = 1'b1;
            end else begin
              if (!t_rdy[c] || t_ovf[c]) err[3*c+2] = 1'b1;
            end
          end
        end
        eof_prev[c] = t_eof[c];
      end
      if (t_clr) begin
        m_flag = '0; m_cnt = 0; m_fv = 1'b0; m_fch = 0; m_ftype = 0;
      end
      m_flag = m_flag | err;
      m_cnt  = m_cnt + $countones(err);
      if (m_cnt > CNT_MAX) m_cnt = CNT_MAX;
      if (!m_fv && err != '0) begin
        idx = 0;
        for (int i = NB-1; i >= 0; i--) if (err[i]) idx = i;
        m_fv = 1'b1; m_fch = idx / 3; m_ftype = idx % 3;
      end
    end
    e.flag = m_flag; e.cnt = m_cnt; e.fv = m_fv; e.fch = m_fch; e.ftype = m_ftype;
    exp_q.push_back(e);
    cyc++;
  endtask

  task automatic step();
    @(negedge Clk);
    Rst                = t_rst;
    bus.Enable         = t_en;
    bus.ClrErr         = t_clr;
    bus.Rx             = t_rx;
    bus.Rx_FlagDetect  = t_fd;
    bus.Rx_ValidFrame  = t_vf;
    bus.Rx_AbortDetect = t_ad;
    bus.Rx_AbortSignal = t_as;
    bus.Rx_EoF         = t_eof;
    bus.Rx_Overflow    = t_ovf;
    bus.Rx_FrameError  = t_fe;
    bus.Rx_Ready       = t_rdy;
    model_step();
  endtask

  task automatic idle_inputs();
    t_rst = 1'b0; t_en = 1'b1; t_clr = 1'b0;
    t_rx = '1; t_fd = '0; t_vf = '0; t_ad = '0; t_as = '0;
    t_eof = '0; t_ovf = '0; t_fe = '0; t_rdy = '0;
  endtask

  task automatic direct_check(string tag, logic [NB-1:0] flag, int cnt, bit fv, int fch, int ftype);
    @(posedge Clk);
    #2;
    check({tag, ".ErrFlag"}, 32'(bus.ErrFlag), 32'(flag));
    check({tag, ".ErrCnt"}, 32'(bus.ErrCnt), 32'(cnt));
    check({tag, ".FirstErrValid"}, 32'(bus.FirstErrValid), 32'(fv));
    if (fv) begin
      check({tag, ".FirstErrCh"}, 32'(bus.FirstErrCh), 32'(fch));
      check({tag, ".FirstErrType"}, 32'(bus.FirstErrType), 32'(ftype));
    end
    $display("phase %s done at cycle %0d ErrCnt=%0d", tag, cyc, bus.ErrCnt);
  endtask

  task automatic random_inputs();
    int r;
    t_rst = ($urandom_range(0, 999) < 3);
    t_clr = ($urandom_range(0, 99) < 2);
    if (dis_left > 0) begin
      t_en = 1'b0;
      dis_left--;
    end else begin
      t_en = 1'b1;
      if ($urandom_range(0, 99) < 2) dis_left = $urandom_range(1, 6);
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (chunk_len[c] == 0) begin
        r = $urandom_range(0, 99);
        if (r < 35)      begin chunk_word[c] = 8'h7E; chunk_len[c] = 8; end
        else if (r < 50) begin chunk_word[c] = 8'h7E; chunk_len[c] = 7; end
        else             begin chunk_word[c] = 8'($urandom); chunk_len[c] = 8; end
      end
      t_rx[c] = chunk_word[c][chunk_len[c]-1];
      chunk_len[c]--;
      t_fd[c]  = flag_due[c][cyc] ? ($urandom_range(0, 99) < 85) : ($urandom_range(0, 99) < 3);
      t_as[c]  = abrt_due[c][cyc] ? ($urandom_range(0, 99) < 85) : ($urandom_range(0, 99) < 10);
      t_ad[c]  = ($urandom_range(0, 99) < 8);
      t_vf[c]  = ($urandom_range(0, 99) < 60);
      if ($urandom_range(0, 99) < 12) t_eof[c] = ~t_eof[c];
      t_ovf[c] = ($urandom_range(0, 99) < 15);
      t_fe[c]  = ($urandom_range(0, 99) < 15);
      t_rdy[c] = (chk_due[c] == cyc) ? ($urandom_range(0, 99) < 20) : ($urandom_range(0, 99) < 55);
    end
  endtask

  // Monitor: every cycle after stimulus starts the DUT presents a full status word
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb.ErrFlag", 32'(bus.ErrFlag), 32'(e.flag));
        check("sb.ErrCnt", 32'(bus.ErrCnt), 32'(e.cnt));
        check("sb.FirstErrValid", 32'(bus.FirstErrValid), 32'(e.fv));
        check("sb.FirstErrCh", 32'(bus.FirstErrCh), 32'(e.fch));
        check("sb.FirstErrType", 32'(bus.FirstErrType), 32'(e.ftype));
      end
    end
  end

  initial begin
    logic [7:0] pat;
    pat = 8'h7E;
    for (int c = 0; c < NUM_CH; c++) begin
      nbits[c] = 0; chk_due[c] = -1; eof_prev[c] = 1'b0; chunk_len[c] = 0; chunk_word[c] = '0;
    end
    m_flag = '0; m_cnt = 0; m_fv = 1'b0; m_fch = 0; m_ftype = 0;
    Rst = 1'b1;
    bus.Enable = 1'b0; bus.ClrErr = 1'b0; bus.Rx = '0; bus.Rx_FlagDetect = '0;
    bus.Rx_ValidFrame = '0; bus.Rx_AbortDetect = '0; bus.Rx_AbortSignal = '0; bus.Rx_EoF = '0;
    bus.Rx_Overflow = '0; bus.Rx_FrameError = '0; bus.Rx_Ready = '0;

    // Reset state
    idle_inputs(); t_rst = 1'b1;
    repeat (3) step();
    direct_check("reset", '0, 0, 1'b0, 0, 0);

    // Flag on ch0..ch2; only ch0 gets its FlagDetect, ch1/ch2 fail in the same cycle
    for (int i = 0; i < 8; i++) begin
      idle_inputs();
      t_rx = {1'b1, pat[7-i], pat[7-i], pat[7-i]};
      t_fd[0] = flag_due[0][cyc];
      step();
    end
    repeat (3) begin
      idle_inputs();
      t_fd[0] = flag_due[0][cyc];
      step();
    end
    direct_check("flag", 12'h048, 2, 1'b1, 1, 0);

    // Abort miss on ch3 in the same cycle as ClrErr
    idle_inputs(); t_ad[3] = 1'b1; t_vf[3] = 1'b1; step();
    idle_inputs(); t_clr = 1'b1; step();
    idle_inputs(); step();
    direct_check("abort_clr", 12'h400, 1, 1'b1, 3, 1);

    // EoF with AbortSignal then Ready high: status error; then Ready low: clean
    idle_inputs(); t_clr = 1'b1; step();
    idle_inputs(); t_eof[0] = 1'b1; t_as[0] = 1'b1; step();
    idle_inputs(); t_eof[0] = 1'b1; t_as[0] = 1'b1; t_rdy[0] = 1'b1; step();
    direct_check("status_rdy", 12'h004, 1, 1'b1, 0, 2);
    idle_inputs(); t_clr = 1'b1; step();
    idle_inputs(); t_eof[0] = 1'b1; t_as[0] = 1'b1; step();
    idle_inputs(); t_eof[0] = 1'b1; step();
    direct_check("status_ok", '0, 0, 1'b0, 0, 0);

    // Count saturation: 4 abort misses per cycle
    idle_inputs(); t_clr = 1'b1; step();
    repeat (10) begin
      idle_inputs(); t_ad = '1; t_vf = '1; step();
    end
    idle_inputs(); step();
    direct_check("saturate", 12'h492, CNT_MAX, 1'b1, 0, 1);

    // Expectation dropped by Enable=0
    idle_inputs(); t_clr = 1'b1; step();
    idle_inputs(); t_ad[0] = 1'b1; t_vf[0] = 1'b1; step();
    idle_inputs(); t_en = 1'b0; step();
    idle_inputs(); step();
    direct_check("enable_drop", '0, 0, 1'b0, 0, 0);

    // Reset in the middle of a flag: the window restarts, so no flag is expected
    idle_inputs(); t_rx[0] = 1'b0; step();
    idle_inputs(); step();
    idle_inputs(); step();
    idle_inputs(); t_rst = 1'b1; step();
    idle_inputs(); step();
    idle_inputs(); step();
    idle_inputs(); step();
    idle_inputs(); t_rx[0] = 1'b0; step();
    repeat (4) begin idle_inputs(); step(); end
    direct_check("rst_mid_flag", '0, 0, 1'b0, 0, 0);

    // Randomized traffic
    idle_inputs();
    for (int n = 0; n < 4000; n++) begin
      random_inputs();
      step();
    end
    @(posedge Clk);
    #2;
    $display("phase random done at cycle %0d ErrCnt=%0d", cyc, bus.ErrCnt);
    check("sb.drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
